// File: rtl/ccff_chain_loader_pkg.sv
// ============================================================================
// Module : ccff_chain_loader_pkg
// Desc   : Shared FSM state encoding for the ccff chain loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ccff_chain_loader_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ccff_loader_piso.sv
// ============================================================================
// Module : ccff_loader_piso
// Desc   : WORD_W parallel-in serial-out register, MSB first, with held-bit count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ccff_loader_piso #(
  parameter int WORD_W = 8,
  parameter int HELD_W = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              msb,
  output logic [HELD_W-1:0] held
);

  logic [WORD_W-1:0] data;

  // A load in the same cycle as a shift replaces the bit being shifted out.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data <= '0;
      held <= '0;
    end else if (load) begin
      data <= din;
      held <= HELD_W'(WORD_W);
    end else if (shift) begin
      data <= data << 1;
      held <= held - HELD_W'(1);
    end
  end

  assign msb = data[WORD_W-1];

endmodule

`default_nettype wire

// File: rtl/ccff_chain_loader.sv
// ============================================================================
// Module : ccff_chain_loader
// Desc   : Serialises bitstream words MSB-first into the ccff configuration
//          chain, gating exactly CHAIN_LEN shifts.
// Config : CCFF_CHAIN_LOADER_READBACK_EN adds a recirculating VERIFY pass
//          with parity comparison reported on err.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int                 HELD_W   = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [STATE_W-1:0] S_IDLE   = ST_IDLE;
  localparam logic [STATE_W-1:0] S_LOAD   = ST_LOAD;
  localparam logic [STATE_W-1:0] S_DONE   = ST_DONE;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  localparam logic [STATE_W-1:0] S_VERIFY = ST_VERIFY;
`endif

  logic [STATE_W-1:0] state;
  logic [HELD_W-1:0]  held;
  logic               piso_msb;
  logic               piso_load;
  logic               piso_clear;
  logic               in_load;
  logic               load_shift;
  logic               last_bit;
  logic               covered;
  logic [31:0]        need;

  ccff_loader_piso #(
    .WORD_W (WORD_W),
    .HELD_W (HELD_W)
  ) u_piso (
    .clk   (prog_clk),
    .rst   (pReset),
    .clear (piso_clear),
    .load  (piso_load),
    .shift (load_shift),
    .din   (word_data),
    .msb   (piso_msb),
    .held  (held)
  );

  // Stop requesting words once held bits cover what the chain still needs.
  always_comb begin
    in_load    = (state == S_LOAD);
    need       = 32'(CHAIN_LEN) - 32'(bit_count);
    covered    = (32'(held) >= need);
    load_shift = in_load && (held != '0);
    word_ready = in_load && !covered &&
                 ((held == '0) || ((held == HELD_W'(1)) && load_shift));
    piso_load  = word_valid && word_ready;
    last_bit   = (bit_count == LAST_CNT);
    piso_clear = load_shift && last_bit;
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  logic in_verify;
  logic par_load;
  logic par_ver;

  assign in_verify     = (state == S_VERIFY);
  assign config_enable = in_load || in_verify;
  assign ccff_shift_en = load_shift || in_verify;
  assign ccff_head     = in_verify ? ccff_tail : (load_shift && piso_msb);
`else
  logic unused_tail;

  assign unused_tail   = ccff_tail;
  assign config_enable = in_load;
  assign ccff_shift_en = load_shift;
  assign ccff_head     = load_shift && piso_msb;
  assign err           = 1'b0;
`endif

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state     <= S_IDLE;
      bit_count <= '0;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
      err       <= 1'b0;
      par_load  <= 1'b0;
      par_ver   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            state     <= S_LOAD;
            bit_count <= '0;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
            err       <= 1'b0;
            par_load  <= 1'b0;
            par_ver   <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (load_shift) begin
            bit_count <= bit_count + CNT_W'(1);
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
            par_load  <= par_load ^ piso_msb;
            if (last_bit) begin
              state     <= S_VERIFY;
              bit_count <= '0;
            end
`else
            if (last_bit) begin
              state <= S_DONE;
            end
`endif
          end
        end
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        // Full recirculation restores the chain while its bits stream past the tail.
        S_VERIFY: begin
          bit_count <= bit_count + CNT_W'(1);
          par_ver   <= par_ver ^ ccff_tail;
          if (last_bit) begin
            state <= S_DONE;
            err   <= par_load ^ par_ver ^ ccff_tail;
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
// ============================================================================
// Module : tb_ccff_chain_loader
// Desc   : Directed self-checking bench; DUT A has a 64-bit chain, DUT B 20 bits.
// Config : CCFF_CHAIN_LOADER_READBACK_EN selects readback expectations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ccff_chain_loader;

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_start = 1'b0, a_valid = 1'b0;
  logic [7:0] a_data  = '0;
  logic       a_ready, a_head, a_shift, a_cfg, a_tail, a_busy, a_done, a_err;
  logic [6:0] a_bc;

  logic       b_start = 1'b0, b_valid = 1'b0;
  logic [7:0] b_data  = '0;
  logic       b_ready, b_head, b_shift, b_cfg, b_tail, b_busy, b_done, b_err;
  logic [4:0] b_bc;

  ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(8)) u_dut_a (
    .prog_clk(clk), .pReset(rst), .cfg_start(a_start), .word_valid(a_valid),
    .word_data(a_data), .word_ready(a_ready), .ccff_head(a_head),
    .ccff_shift_en(a_shift), .config_enable(a_cfg), .ccff_tail(a_tail),
    .busy(a_busy), .done(a_done), .err(a_err), .bit_count(a_bc)
  );

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut_b (
    .prog_clk(clk), .pReset(rst), .cfg_start(b_start), .word_valid(b_valid),
    .word_data(b_data), .word_ready(b_ready), .ccff_head(b_head),
    .ccff_shift_en(b_shift), .config_enable(b_cfg), .ccff_tail(b_tail),
    .busy(b_busy), .done(b_done), .err(b_err), .bit_count(b_bc)
  );

  // Chain models; stuck forces the head cell of chain A to 0.
  logic [63:0] a_chain = '0;
  logic [19:0] b_chain = '0;
  logic        stuck   = 1'b0;
  always @(posedge clk) begin
    if (a_shift) a_chain <= {a_chain[62:0], stuck ? 1'b0 : a_head};
    if (b_shift) b_chain <= {b_chain[18:0], b_head};
  end
  assign a_tail = a_chain[63];
  assign b_tail = b_chain[19];

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Negedge monitors
  int          cyc = 0;
  logic [63:0] a_cap;
  int          a_capn, a_first, a_last, a_shifts, a_dn, a_dcyc, a_hold;
  logic [6:0]  a_dbc, a_pbc;
  logic        a_derr, a_pcfg, a_pshift;
  logic [1:0]  a_dside;
  logic [19:0] b_cap;
  int          b_capn, b_shifts, b_dn;
  logic [4:0]  b_dbc;
  logic        b_derr;

  always @(negedge clk) begin
    cyc++;
    if (a_shift) begin
      a_shifts++;
      if (a_capn < 64) begin
        a_cap = {a_cap[62:0], a_head};
        if (a_capn == 0) a_first = cyc;
        a_capn++;
        if (a_capn == 64) a_last = cyc;
      end
    end
    if (a_done) begin
      a_dn++; a_dcyc = cyc; a_dbc = a_bc; a_derr = a_err; a_dside = {a_cfg, a_shift};
    end
    if (a_pcfg && a_cfg && !a_pshift && (a_bc != a_pbc)) a_hold++;
    a_pbc = a_bc; a_pcfg = a_cfg; a_pshift = a_shift;
    if (b_shift) begin
      b_shifts++;
      if (b_capn < 20) begin
        b_cap = {b_cap[18:0], b_head};
        b_capn++;
      end
    end
    if (b_done) begin
      b_dn++; b_dbc = b_bc; b_derr = b_err;
    end
  end

  task automatic clr_mon();
    a_cap = '0; a_capn = 0; a_first = 0; a_last = 0; a_shifts = 0; a_dn = 0;
    a_dcyc = 0; a_hold = 0; a_dbc = '0; a_derr = 1'b0; a_dside = '0;
    a_pcfg = 1'b0; a_pshift = 1'b0; a_pbc = '0;
    b_cap = '0; b_capn = 0; b_shifts = 0; b_dn = 0; b_dbc = '0; b_derr = 1'b0;
  endtask

  task automatic set_valid(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin b_valid = v; b_data = d; end
    else     begin a_valid = v; a_data = d; end
  endtask

  task automatic start(input bit sel);
    @(negedge clk);
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0; a_start = 1'b0;
  endtask

  task automatic feed(input bit sel, input int n, input int gap, input logic [7:0] w [8]);
    int k;
    for (int i = 0; i < n; i++) begin
      set_valid(sel, 1'b1, w[i]);
      k = 0;
      while (!(sel ? b_ready : a_ready) && k < 300) begin
        @(negedge clk);
        k++;
      end
      if (k >= 300) begin
        chk("feed_timeout", 64'(k), 64'd0);
        set_valid(sel, 1'b0, 8'h00);
        return;
      end
      @(negedge clk);
      set_valid(sel, 1'b0, 8'h00);
      if (gap > 0 && i < n - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_done(input bit sel);
    int k = 0;
    while (((sel ? b_dn : a_dn) == 0) && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk(sel ? "b_done_timeout" : "a_done_timeout", 64'(k >= 600), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  logic [7:0] wv [8];
  logic       rdy_or;
  int         kk;

  initial begin
    clr_mon();
    repeat (2) @(negedge clk);
    chk("a_reset_outs", 64'({a_ready, a_head, a_shift, a_cfg, a_busy, a_done, a_err, a_bc}), 64'd0);
    chk("b_reset_outs", 64'({b_ready, b_head, b_shift, b_cfg, b_busy, b_done, b_err, b_bc}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: eight 0xA5 words back-to-back
    clr_mon();
    for (int i = 0; i < 8; i++) wv[i] = 8'hA5;
    start(1'b0);
    feed(1'b0, 8, 0, wv);
    wait_done(1'b0);
    chk("t1_pattern", a_cap, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("t1_contig_span", 64'(a_last - a_first + 1), 64'd64);
    chk("t1_done_latency", 64'(a_dcyc - a_last), RB ? 64'd65 : 64'd1);
    chk("t1_done_pulses", 64'(a_dn), 64'd1);
    chk("t1_done_count", 64'(a_dbc), 64'd64);
    chk("t1_done_side", 64'(a_dside), 64'd0);
    chk("t1_total_shifts", 64'(a_shifts), RB ? 64'd128 : 64'd64);
    chk("t1_err", 64'(a_derr), 64'd0);
    chk("t1_chain", a_chain, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("t1_idle_busy", 64'(a_busy), 64'd0);

    // 2: three-cycle valid gaps after each word drains
    clr_mon();
    wv = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    start(1'b0);
    feed(1'b0, 8, 11, wv);
    wait_done(1'b0);
    chk("t2_pattern", a_cap, 64'h0123_4567_89AB_CDEF);
    chk("t2_span", 64'(a_last - a_first + 1), 64'd92);
    chk("t2_hold", 64'(a_hold), 64'd0);
    chk("t2_done_count", 64'(a_dbc), 64'd64);

    // 3: 20-bit chain, last word's low nibble discarded
    clr_mon();
    wv = '{8'hC3, 8'h5A, 8'h9F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    start(1'b1);
    feed(1'b1, 3, 0, wv);
    b_valid = 1'b1; b_data = 8'hFF;
    rdy_or = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rdy_or = rdy_or | b_ready;
      @(negedge clk);
    end
    b_valid = 1'b0;
    wait_done(1'b1);
    chk("t3_ready_after_last", 64'(rdy_or), 64'd0);
    chk("t3_pattern", 64'(b_cap), 64'hC_35A9);
    chk("t3_shifts", 64'(b_shifts), RB ? 64'd40 : 64'd20);
    chk("t3_done_count", 64'(b_dbc), 64'd20);
    chk("t3_done_pulses", 64'(b_dn), 64'd1);
    chk("t3_err", 64'(b_derr), 64'd0);

    // 4: reset at bit 30, then clean reload
    clr_mon();
    start(1'b0);
    a_valid = 1'b1; a_data = 8'hA5;
    kk = 0;
    while (a_bc != 7'd30 && kk < 300) begin
      @(negedge clk);
      kk++;
    end
    chk("t4_reach30", 64'(kk >= 300), 64'd0);
    rst = 1'b1; a_valid = 1'b0;
    @(negedge clk);
    chk("t4_reset_outs", 64'({a_ready, a_head, a_shift, a_cfg, a_busy, a_done, a_err, a_bc}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    clr_mon();
    start(1'b0);
    a_valid = 1'b1; a_data = 8'h5A;
    wait_done(1'b0);
    a_valid = 1'b0;
    chk("t4_reload_pattern", a_cap, 64'h5A5A_5A5A_5A5A_5A5A);
    chk("t4_reload_count", 64'(a_dbc), 64'd64);
    chk("t4_reload_chain", a_chain, 64'h5A5A_5A5A_5A5A_5A5A);

    // 5: cfg_start during LOAD is ignored
    clr_mon();
    for (int i = 0; i < 8; i++) wv[i] = 8'h3C;
    start(1'b0);
    feed(1'b0, 1, 0, wv);
    repeat (10) @(negedge clk);
    chk("t5_pre_count", 64'(a_bc), 64'd8);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("t5_count_hold", 64'(a_bc), 64'd8);
    chk("t5_still_load", 64'({a_busy, a_cfg}), 64'd3);
    feed(1'b0, 7, 0, wv);
    wait_done(1'b0);
    chk("t5_pattern", a_cap, 64'h3C3C_3C3C_3C3C_3C3C);
    chk("t5_done_pulses", 64'(a_dn), 64'd1);
    chk("t5_hold", 64'(a_hold), 64'd0);

    // 6: stuck-at-0 head cell with odd-parity data
    clr_mon();
    stuck = 1'b1;
    wv = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA7};
    start(1'b0);
    feed(1'b0, 8, 0, wv);
    wait_done(1'b0);
    stuck = 1'b0;
    chk("t6_err_at_done", 64'(a_derr), 64'(RB));
    chk("t6_err_sticky", 64'(a_err), 64'(RB));
    start(1'b0);
    chk("t6_err_cleared", 64'(a_err), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
